// File: rtl/rotary_pkg.sv
// -----------------------------------------------------------------------------
// rotary_pkg
// Shared definitions for the rotary position counter:
//   rot_state_e : acceleration FSM states (IDLE, SLOW, FAST)
//   DIR_CW      : i_cnt_cw value for an increment
//   DIR_CCW     : i_cnt_cw value for a decrement
//   EXT_GUARD   : extra guard bits used by the position arithmetic so that
//                 value + step and value + range never overflow
// No ports (package).
// -----------------------------------------------------------------------------
package rotary_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } rot_state_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam int EXT_GUARD = 2;

endpackage

// File: rtl/rotary_position_counter_if.sv
// -----------------------------------------------------------------------------
// rotary_position_counter_if
// Bundles the event/load inputs and the position outputs of the rotary
// position counter.
//   i_cnt, i_cnt_cw      : rotation event pulse and its direction
//   i_load, i_load_value : synchronous load strobe and value
//   o_value              : registered position
//   o_changed            : one-cycle pulse when o_value takes a new value
//   o_at_min, o_at_max   : registered bound flags
//   o_fast               : acceleration FSM is in FAST
// Modports: master (event source / consumer), slave (the counter).
// -----------------------------------------------------------------------------
interface rotary_position_counter_if #(
  parameter int WIDTH = 8
);

  logic             i_cnt;
  logic             i_cnt_cw;
  logic             i_load;
  logic [WIDTH-1:0] i_load_value;

  logic [WIDTH-1:0] o_value;
  logic             o_changed;
  logic             o_at_min;
  logic             o_at_max;
  logic             o_fast;

  modport master (
    output i_cnt,
    output i_cnt_cw,
    output i_load,
    output i_load_value,
    input  o_value,
    input  o_changed,
    input  o_at_min,
    input  o_at_max,
    input  o_fast
  );

  modport slave (
    input  i_cnt,
    input  i_cnt_cw,
    input  i_load,
    input  i_load_value,
    output o_value,
    output o_changed,
    output o_at_min,
    output o_at_max,
    output o_fast
  );

endinterface

// File: rtl/rotary_gap_timer.sv
// -----------------------------------------------------------------------------
// rotary_gap_timer
// Measures the number of clocks since the last rotation event. The count is
// cleared by i_clear, otherwise increments and saturates at WINDOW. It comes
// out of reset already saturated, so the first event after reset always sees
// an expired streak.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_clear    : restart the gap measurement (one per event)
//   o_expired  : count has reached WINDOW
// -----------------------------------------------------------------------------
module rotary_gap_timer #(
  parameter int WINDOW = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_expired
);

  localparam int            TW    = $clog2(WINDOW + 1);
  localparam logic [TW-1:0] WIN_T = TW'(WINDOW);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (cnt_q != WIN_T) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= WIN_T;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = (cnt_q == WIN_T);

endmodule

// File: rtl/rotary_position_counter.sv
// -----------------------------------------------------------------------------
// rotary_position_counter
// Bounded position counter driven by encoder events, with an acceleration
// FSM: a streak of ACCEL_COUNT same-direction events, each within
// ACCEL_WINDOW clocks of the previous one, switches the step from 1 to
// ACCEL_STEP. Bounds either saturate (WRAP=0) or wrap (WRAP=1).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of rotary_position_counter_if
//             (i_cnt, i_cnt_cw, i_load, i_load_value in;
//              o_value, o_changed, o_at_min, o_at_max, o_fast out)
// -----------------------------------------------------------------------------
module rotary_position_counter
  import rotary_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 100,
  parameter int INIT_VAL     = 0,
  parameter int WRAP         = 0,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_COUNT  = 4,
  parameter int ACCEL_STEP   = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  rotary_position_counter_if.slave  bus
);

  // Arithmetic is done WIDTH+2 bits wide: MAX_VAL + ACCEL_STEP and
  // value + range both stay below 2**(WIDTH+1), so no intermediate wraps.
  localparam int             EXT     = WIDTH + EXT_GUARD;
  localparam logic [EXT-1:0] MIN_X   = EXT'(MIN_VAL);
  localparam logic [EXT-1:0] MAX_X   = EXT'(MAX_VAL);
  localparam logic [EXT-1:0] RANGE_X = EXT'(MAX_VAL - MIN_VAL + 1);
  localparam logic [EXT-1:0] ACCEL_X = EXT'(ACCEL_STEP);

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_VAL);

  localparam int            SW          = $clog2(ACCEL_COUNT + 1);
  localparam logic [SW-1:0] STREAK_FULL = SW'(ACCEL_COUNT);
  // With a streak length of one, the very first event already qualifies.
  localparam bit            FIRST_FAST  = (ACCEL_COUNT <= 1);

  // ---------------------------------------------------------------------------
  // Gap timer: restarted by every raw event, including one swallowed by load.
  // ---------------------------------------------------------------------------
  logic expired;

  rotary_gap_timer #(
    .WINDOW (ACCEL_WINDOW)
  ) u_gap_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (bus.i_cnt),
    .o_expired (expired)
  );

  // ---------------------------------------------------------------------------
  // Acceleration FSM
  // ---------------------------------------------------------------------------
  rot_state_e    state_q;
  logic [SW-1:0] streak_q;
  logic          dir_q;
  logic          fast_q;

  // An event arriving in the same cycle the window expires is no longer part
  // of the streak, so it gets the slow step even if FAST has not yet been
  // left on a quiet cycle.
  logic fast_step;
  assign fast_step = (state_q == FAST) && !expired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      dir_q    <= DIR_CCW;
      fast_q   <= 1'b0;
    end else if (bus.i_load) begin
      state_q  <= IDLE;
      streak_q <= '0;
      fast_q   <= 1'b0;
    end else if (bus.i_cnt) begin
      dir_q <= bus.i_cnt_cw;
      if ((state_q == IDLE) || expired || (bus.i_cnt_cw != dir_q)) begin
        // Start of a fresh streak.
        streak_q <= SW'(1);
        if (FIRST_FAST) begin
          state_q <= FAST;
          fast_q  <= 1'b1;
        end else begin
          state_q <= SLOW;
          fast_q  <= 1'b0;
        end
      end else if (state_q == SLOW) begin
        streak_q <= streak_q + SW'(1);
        if ((streak_q + SW'(1)) == STREAK_FULL) begin
          state_q <= FAST;
          fast_q  <= 1'b1;
        end
      end
      // FAST with same direction inside the window: hold.
    end else if (expired && (state_q != IDLE)) begin
      state_q  <= IDLE;
      streak_q <= '0;
      fast_q   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Position datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             changed_q;
  logic             at_min_q;
  logic             at_max_q;

  logic [EXT-1:0] cur_x;
  logic [EXT-1:0] step_x;
  logic [EXT-1:0] ld_x;
  logic [EXT-1:0] sum_x;
  logic [EXT-1:0] calc_x;

  always_comb begin
    cur_x  = EXT'(value_q);
    step_x = fast_step ? ACCEL_X : EXT'(1);
    ld_x   = EXT'(bus.i_load_value);
    sum_x  = cur_x + step_x;
    calc_x = cur_x;

    if (bus.i_load) begin
      if (ld_x < MIN_X) begin
        calc_x = MIN_X;
      end else if (ld_x > MAX_X) begin
        calc_x = MAX_X;
      end else begin
        calc_x = ld_x;
      end
    end else if (bus.i_cnt) begin
      if (bus.i_cnt_cw == DIR_CW) begin
        if (sum_x > MAX_X) begin
          calc_x = (WRAP != 0) ? (sum_x - RANGE_X) : MAX_X;
        end else begin
          calc_x = sum_x;
        end
      end else begin
        // Compare against MIN+step instead of forming cur-step, which would
        // underflow the unsigned arithmetic.
        if (cur_x < (MIN_X + step_x)) begin
          calc_x = (WRAP != 0) ? (cur_x + RANGE_X - step_x) : MIN_X;
        end else begin
          calc_x = cur_x - step_x;
        end
      end
    end

    value_d = WIDTH'(calc_x);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q   <= INIT_W;
      changed_q <= 1'b0;
      at_min_q  <= (INIT_W == MIN_W);
      at_max_q  <= (INIT_W == MAX_W);
    end else begin
      value_q   <= value_d;
      changed_q <= (value_d != value_q);
      at_min_q  <= (value_d == MIN_W);
      at_max_q  <= (value_d == MAX_W);
    end
  end

  assign bus.o_value   = value_q;
  assign bus.o_changed = changed_q;
  assign bus.o_at_min  = at_min_q;
  assign bus.o_at_max  = at_max_q;
  assign bus.o_fast    = fast_q;

endmodule

// File: tb/tb_rotary_position_counter.sv
// -----------------------------------------------------------------------------
// tb_rotary_position_counter
// Drives a saturating and a wrapping counter with identical stimulus. A
// behavioural model computes the expected outputs of each instance when the
// stimulus is applied, pushes them to a per-instance queue, and the entries
// are popped and compared one clock later.
// -----------------------------------------------------------------------------
module tb_rotary_position_counter;

  localparam int W     = 8;
  localparam int MINV  = 0;
  localparam int MAXV  = 100;
  localparam int INITV = 0;
  localparam int WIN   = 40;
  localparam int ACNT  = 4;
  localparam int ASTP  = 5;
  localparam int RANGE = MAXV - MINV + 1;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rotary_position_counter_if #(.WIDTH(W)) bus_sat  ();
  rotary_position_counter_if #(.WIDTH(W)) bus_wrap ();

  rotary_position_counter #(
    .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INITV), .WRAP(0),
    .ACCEL_WINDOW(WIN), .ACCEL_COUNT(ACNT), .ACCEL_STEP(ASTP)
  ) dut_sat (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_sat)
  );

  rotary_position_counter #(
    .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INITV), .WRAP(1),
    .ACCEL_WINDOW(WIN), .ACCEL_COUNT(ACNT), .ACCEL_STEP(ASTP)
  ) dut_wrap (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_wrap)
  );

  typedef struct {
    int value;
    bit changed;
    bit fast;
    bit at_min;
    bit at_max;
  } exp_t;

  // st: 0 = idle, 1 = slow, 2 = fast
  typedef struct {
    int pos;
    int st;
    int streak;
    bit dir;
    int gap;
  } mdl_t;

  mdl_t m [2];
  exp_t q_sat [$];
  exp_t q_wrap [$];

  int n_checks = 0;
  int n_fail   = 0;
  int chg_sat  = 0;
  int chg_wrap = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].pos    = INITV;
      m[k].st     = 0;
      m[k].streak = 0;
      m[k].dir    = 1'b0;
      m[k].gap    = WIN;
    end
    q_sat.delete();
    q_wrap.delete();
  endtask

  task automatic model_update(input int k, input bit cnt, input bit cw,
                              input bit ld, input int lv, output exp_t e);
    bit expd;
    int old;
    int nv;
    int stp;
    expd = (m[k].gap >= WIN);
    old  = m[k].pos;
    nv   = old;
    if (ld) begin
      nv = (lv < MINV) ? MINV : ((lv > MAXV) ? MAXV : lv);
      m[k].st     = 0;
      m[k].streak = 0;
    end else if (cnt) begin
      stp = (m[k].st == 2 && !expd) ? ASTP : 1;
      nv  = cw ? old + stp : old - stp;
      if (k == 1) begin
        if (nv > MAXV) nv = nv - RANGE;
        else if (nv < MINV) nv = nv + RANGE;
      end else begin
        if (nv > MAXV) nv = MAXV;
        else if (nv < MINV) nv = MINV;
      end
      if (m[k].st == 0 || expd || cw != m[k].dir) begin
        m[k].streak = 1;
        m[k].st     = (ACNT <= 1) ? 2 : 1;
      end else if (m[k].st == 1) begin
        m[k].streak = m[k].streak + 1;
        if (m[k].streak >= ACNT) m[k].st = 2;
      end
      m[k].dir = cw;
    end else if (expd) begin
      m[k].st     = 0;
      m[k].streak = 0;
    end
    m[k].gap  = cnt ? 0 : ((m[k].gap < WIN) ? m[k].gap + 1 : WIN);
    m[k].pos  = nv;
    e.value   = nv;
    e.changed = (nv != old);
    e.fast    = (m[k].st == 2);
    e.at_min  = (nv == MINV);
    e.at_max  = (nv == MAXV);
  endtask

  task automatic drive(input bit cnt, input bit cw, input bit ld, input int lv);
    bus_sat.i_cnt         = cnt;
    bus_sat.i_cnt_cw      = cw;
    bus_sat.i_load        = ld;
    bus_sat.i_load_value  = W'(lv);
    bus_wrap.i_cnt        = cnt;
    bus_wrap.i_cnt_cw     = cw;
    bus_wrap.i_load       = ld;
    bus_wrap.i_load_value = W'(lv);
  endtask

  // One clock of stimulus followed by a scoreboard compare for both DUTs.
  task automatic cyc(input bit cnt, input bit cw, input bit ld, input int lv);
    exp_t e;
    @(negedge clk);
    drive(cnt, cw, ld, lv);
    model_update(0, cnt, cw, ld, lv, e);
    q_sat.push_back(e);
    model_update(1, cnt, cw, ld, lv, e);
    q_wrap.push_back(e);
    @(posedge clk);
    #1;
    check_eq("sat_sb_depth", q_sat.size(), 1);
    if (q_sat.size() > 0) begin
      e = q_sat.pop_front();
      check_eq("sat_value",   int'(bus_sat.o_value),   e.value);
      check_eq("sat_changed", int'(bus_sat.o_changed), int'(e.changed));
      check_eq("sat_fast",    int'(bus_sat.o_fast),    int'(e.fast));
      check_eq("sat_at_min",  int'(bus_sat.o_at_min),  int'(e.at_min));
      check_eq("sat_at_max",  int'(bus_sat.o_at_max),  int'(e.at_max));
    end
    check_eq("wrap_sb_depth", q_wrap.size(), 1);
    if (q_wrap.size() > 0) begin
      e = q_wrap.pop_front();
      check_eq("wrap_value",   int'(bus_wrap.o_value),   e.value);
      check_eq("wrap_changed", int'(bus_wrap.o_changed), int'(e.changed));
      check_eq("wrap_fast",    int'(bus_wrap.o_fast),    int'(e.fast));
      check_eq("wrap_at_min",  int'(bus_wrap.o_at_min),  int'(e.at_min));
      check_eq("wrap_at_max",  int'(bus_wrap.o_at_max),  int'(e.at_max));
    end
    chg_sat  += int'(bus_sat.o_changed);
    chg_wrap += int'(bus_wrap.o_changed);
    if (cnt || ld)
      $display("txn t=%0t cnt=%0b cw=%0b load=%0b lv=%0d -> sat=%0d fast=%0b | wrap=%0d fast=%0b",
               $time, cnt, cw, ld, lv, bus_sat.o_value, bus_sat.o_fast,
               bus_wrap.o_value, bus_wrap.o_fast);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
  endtask

  task automatic pulses(input int n, input bit cw, input int spacing);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, cw, 1'b0, 0);
      idle(spacing - 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_sat_value"},  int'(bus_sat.o_value),   INITV);
    check_eq({tag, "_sat_chg"},    int'(bus_sat.o_changed), 0);
    check_eq({tag, "_sat_fast"},   int'(bus_sat.o_fast),    0);
    check_eq({tag, "_sat_min"},    int'(bus_sat.o_at_min),  1);
    check_eq({tag, "_sat_max"},    int'(bus_sat.o_at_max),  0);
    check_eq({tag, "_wrap_value"}, int'(bus_wrap.o_value),  INITV);
    check_eq({tag, "_wrap_fast"},  int'(bus_wrap.o_fast),   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    model_reset();
    chg_sat  = 0;
    chg_wrap = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0);
    model_reset();

    // Basic counting: three slow CW events.
    do_reset();
    pulses(3, 1'b1, 10);
    check_eq("r034_value",   int'(bus_sat.o_value), 3);
    check_eq("r034_changes", chg_sat, 3);
    check_eq("r034_fast",    int'(bus_sat.o_fast), 0);

    // Acceleration: six CW events, fast after the fourth.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 0);
      if (i == 3) check_eq("r035_fast_after3", int'(bus_sat.o_fast), 0);
      if (i == 4) check_eq("r035_fast_after4", int'(bus_sat.o_fast), 1);
      idle(9);
    end
    check_eq("r035_value", int'(bus_sat.o_value), 14);
    check_eq("r035_fast",  int'(bus_sat.o_fast), 1);

    // Window expiry in FAST: next event is slow.
    idle(WIN);
    cyc(1'b1, 1'b1, 1'b0, 0);
    check_eq("r036_value", int'(bus_sat.o_value), 15);
    check_eq("r036_fast",  int'(bus_sat.o_fast), 0);

    // Re-enter FAST, then go quiet past the window.
    pulses(4, 1'b1, 2);
    idle(WIN + 3);
    check_eq("expire_fast", int'(bus_sat.o_fast), 0);

    // Direction reversal in FAST: big step back, streak restarts.
    pulses(4, 1'b1, 1);
    pulses(1, 1'b0, 1);
    pulses(2, 1'b0, 1);

    // Underflow below MIN with acceleration.
    do_reset();
    pulses(6, 1'b0, 2);
    check_eq("under_sat_value",  int'(bus_sat.o_value), 0);
    check_eq("under_sat_chg",    chg_sat, 0);
    check_eq("under_sat_min",    int'(bus_sat.o_at_min), 1);
    check_eq("under_wrap_value", int'(bus_wrap.o_value), 87);

    // Load near MAX then three slow CW events.
    cyc(1'b0, 1'b0, 1'b1, 99);
    idle(2);
    chg_sat  = 0;
    chg_wrap = 0;
    pulses(3, 1'b1, 10);
    check_eq("r037_sat_value",  int'(bus_sat.o_value), 100);
    check_eq("r037_sat_chg",    chg_sat, 1);
    check_eq("r037_sat_max",    int'(bus_sat.o_at_max), 1);
    check_eq("r037_wrap_value", int'(bus_wrap.o_value), 1);
    check_eq("r037_wrap_chg",   chg_wrap, 3);

    // Load wins over a simultaneous event; FSM drops to IDLE.
    do_reset();
    pulses(4, 1'b1, 1);
    cyc(1'b1, 1'b1, 1'b1, 200);
    check_eq("r038_load_value", int'(bus_sat.o_value), 100);
    check_eq("r038_load_fast",  int'(bus_sat.o_fast), 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    check_eq("r038_after_sat",  int'(bus_sat.o_value), 100);
    check_eq("r038_after_wrap", int'(bus_wrap.o_value), 0);

    // Mid-range load.
    cyc(1'b0, 1'b0, 1'b1, 50);
    check_eq("load50_value", int'(bus_sat.o_value), 50);

    // Asynchronous reset in FAST takes effect before the next edge.
    do_reset();
    pulses(5, 1'b1, 1);
    check_eq("pre_arst_value", int'(bus_sat.o_value), 9);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("arst");
    drive(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1'b1, 1'b1, 1'b0, 0);
    check_eq("post_arst_value", int'(bus_sat.o_value), 1);
    check_eq("post_arst_fast",  int'(bus_sat.o_fast), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
